// File: rtl/reg_rename_file_if.sv
// Commit, rename and operand-read bus between the ROB/issue side and the
// rename register file.
//
// Handshake semantics: every strobe here (en_commit, rename_en) is a
// single-cycle qualifier with no back-pressure. The register file always
// accepts a strobe that is high on a rising edge while rdy_in is high. The
// read side is purely combinational. Addresses in, value/busy/tag out in
// the same cycle, with no valid or ready qualifier.
interface reg_rename_file_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
);
    // Commit bus from the ROB
    logic            en_commit;
    logic [TAGW-1:0] commit_rob;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_val;

    // Rename request from issue
    logic            rename_en;
    logic [4:0]      rename_rd;
    logic [TAGW-1:0] rename_rob;

    // Operand read ports
    logic [4:0]      rs1_addr;
    logic [XLEN-1:0] rs1_val;
    logic            rs1_busy;
    logic [TAGW-1:0] rs1_tag;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs2_val;
    logic            rs2_busy;
    logic [TAGW-1:0] rs2_tag;

    // Retired-instruction counter
    logic [31:0]     commit_count;

    // ROB/issue side
    modport master (
        output en_commit, commit_rob, commit_rd, commit_val,
        output rename_en, rename_rd, rename_rob,
        output rs1_addr, rs2_addr,
        input  rs1_val, rs1_busy, rs1_tag,
        input  rs2_val, rs2_busy, rs2_tag,
        input  commit_count
    );

    // Register file side
    modport slave (
        input  en_commit, commit_rob, commit_rd, commit_val,
        input  rename_en, rename_rd, rename_rob,
        input  rs1_addr, rs2_addr,
        output rs1_val, rs1_busy, rs1_tag,
        output rs2_val, rs2_busy, rs2_tag,
        output commit_count
    );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with a per-register rename tag table.
// Commits retire values and release tags only when the committing ROB
// index still owns the register. A flush releases every tag at once.
// Read ports bypass a same-cycle commit but never a same-cycle rename.
module reg_rename_file #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear,
    reg_rename_file_if.slave   bus
);

    // Architectural state. Entry 0 is held at reset values forever, so x0
    // reads as zero, never busy, with tag zero.
    logic [XLEN-1:0] r_regs [NREG];
    logic            r_busy [NREG];
    logic [TAGW-1:0] r_tag  [NREG];
    logic [31:0]     r_commit_count;

    // Read-path intermediates
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_rs1_release;
    logic            w_rs2_release;

    // Retire values, count commits, and maintain the busy/tag table
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
            r_commit_count <= '0;
        end else if (rdy_in) begin
            // A commit always writes and counts, even alongside a flush
            if (bus.en_commit) begin
                if (bus.commit_rd != 5'd0) begin
                    r_regs[bus.commit_rd] <= bus.commit_val;
                end
                r_commit_count <= r_commit_count + 32'd1;
            end
            // Priority per register: flush, then rename, then commit release.
            // A rename to the same register as a commit therefore keeps it
            // busy under the new tag.
            for (int i = 1; i < NREG; i++) begin
                if (clear) begin
                    r_busy[i] <= 1'b0;
                end else if (bus.rename_en && (bus.rename_rd == i[4:0])) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= bus.rename_rob;
                end else if (bus.en_commit && (bus.commit_rd == i[4:0]) &&
                             (r_tag[i] == bus.commit_rob)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Operand read with same-cycle commit bypass on value and busy
    always_comb begin
        w_rs1_hit     = bus.en_commit && (bus.commit_rd == bus.rs1_addr) &&
                        (bus.rs1_addr != 5'd0);
        w_rs2_hit     = bus.en_commit && (bus.commit_rd == bus.rs2_addr) &&
                        (bus.rs2_addr != 5'd0);
        w_rs1_release = bus.en_commit && (bus.commit_rd == bus.rs1_addr) &&
                        (r_tag[bus.rs1_addr] == bus.commit_rob);
        w_rs2_release = bus.en_commit && (bus.commit_rd == bus.rs2_addr) &&
                        (r_tag[bus.rs2_addr] == bus.commit_rob);

        bus.rs1_val  = w_rs1_hit ? bus.commit_val : r_regs[bus.rs1_addr];
        bus.rs1_busy = r_busy[bus.rs1_addr] && !w_rs1_release && !clear;
        bus.rs1_tag  = r_tag[bus.rs1_addr];

        bus.rs2_val  = w_rs2_hit ? bus.commit_val : r_regs[bus.rs2_addr];
        bus.rs2_busy = r_busy[bus.rs2_addr] && !w_rs2_release && !clear;
        bus.rs2_tag  = r_tag[bus.rs2_addr];
    end

    assign bus.commit_count = r_commit_count;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: reset, commit bypass, tag ownership,
// rename/commit collisions, flush, enable gating, x0 and async reset.
module tb_reg_rename_file;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic clear;

    int tests_run;
    int tests_failed;

    reg_rename_file_if #(.XLEN(32), .TAGW(5)) bus ();

    reg_rename_file #(.NREG(32), .XLEN(32), .TAGW(5)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    // Clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Drivers
    task automatic idle();
        bus.en_commit  = 1'b0;
        bus.commit_rob = '0;
        bus.commit_rd  = '0;
        bus.commit_val = '0;
        bus.rename_en  = 1'b0;
        bus.rename_rd  = '0;
        bus.rename_rob = '0;
        clear          = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_commit(input logic [4:0] rd, input logic [4:0] rob,
                                input logic [31:0] val);
        bus.en_commit  = 1'b1;
        bus.commit_rd  = rd;
        bus.commit_rob = rob;
        bus.commit_val = val;
    endtask

    task automatic drive_rename(input logic [4:0] rd, input logic [4:0] rob);
        bus.rename_en  = 1'b1;
        bus.rename_rd  = rd;
        bus.rename_rob = rob;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle();
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd0;
        #2;
        tests_run++; if (bus.rs1_val !== 32'd0) begin tests_failed++; $display("FAIL reset_val got %h exp 0", bus.rs1_val); end
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.commit_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", bus.commit_count); end
        #1 rst_in = 1'b1;
        step();
    endtask

    task automatic test_commit_bypass();
        drive_commit(5'd5, 5'd3, 32'hDEADBEEF);
        bus.rs1_addr = 5'd5;
        #1;
        tests_run++; if (bus.rs1_val !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL bypass_val got %h exp deadbeef", bus.rs1_val); end
        step();
        idle();
        #1;
        tests_run++; if (bus.rs1_val !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL commit_reg got %h exp deadbeef", bus.rs1_val); end
        tests_run++; if (bus.commit_count !== 32'd1) begin tests_failed++; $display("FAIL commit_count1 got %0d exp 1", bus.commit_count); end
    endtask

    task automatic test_rename_commit();
        drive_rename(5'd7, 5'd4);
        step();
        idle();
        bus.rs1_addr = 5'd7;
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b1) begin tests_failed++; $display("FAIL rename_busy got %b exp 1", bus.rs1_busy); end
        tests_run++; if (bus.rs1_tag !== 5'd4) begin tests_failed++; $display("FAIL rename_tag got %0d exp 4", bus.rs1_tag); end
        drive_commit(5'd7, 5'd4, 32'h11);
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL release_bypass_busy got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.rs1_val !== 32'h11) begin tests_failed++; $display("FAIL release_bypass_val got %h exp 11", bus.rs1_val); end
        step();
        idle();
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL release_busy got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.rs1_val !== 32'h11) begin tests_failed++; $display("FAIL release_val got %h exp 11", bus.rs1_val); end
    endtask

    task automatic test_younger_writer();
        drive_rename(5'd7, 5'd4);
        step();
        drive_rename(5'd7, 5'd9);
        step();
        idle();
        bus.rs1_addr = 5'd7;
        drive_commit(5'd7, 5'd4, 32'h22);
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b1) begin tests_failed++; $display("FAIL stale_commit_bypass_busy got %b exp 1", bus.rs1_busy); end
        tests_run++; if (bus.rs1_val !== 32'h22) begin tests_failed++; $display("FAIL stale_commit_bypass_val got %h exp 22", bus.rs1_val); end
        step();
        idle();
        #1;
        tests_run++; if (bus.rs1_val !== 32'h22) begin tests_failed++; $display("FAIL stale_commit_val got %h exp 22", bus.rs1_val); end
        tests_run++; if (bus.rs1_busy !== 1'b1) begin tests_failed++; $display("FAIL stale_commit_busy got %b exp 1", bus.rs1_busy); end
        tests_run++; if (bus.rs1_tag !== 5'd9) begin tests_failed++; $display("FAIL stale_commit_tag got %0d exp 9", bus.rs1_tag); end
        drive_commit(5'd7, 5'd9, 32'h33);
        step();
        idle();
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL owner_commit_busy got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.rs1_val !== 32'h33) begin tests_failed++; $display("FAIL owner_commit_val got %h exp 33", bus.rs1_val); end
        tests_run++; if (bus.commit_count !== 32'd4) begin tests_failed++; $display("FAIL count4 got %0d exp 4", bus.commit_count); end
    endtask

    task automatic test_same_cycle_rename_commit();
        drive_commit(5'd8, 5'd2, 32'h55);
        drive_rename(5'd8, 5'd10);
        step();
        idle();
        bus.rs2_addr = 5'd8;
        #1;
        tests_run++; if (bus.rs2_busy !== 1'b1) begin tests_failed++; $display("FAIL collide_busy got %b exp 1", bus.rs2_busy); end
        tests_run++; if (bus.rs2_tag !== 5'd10) begin tests_failed++; $display("FAIL collide_tag got %0d exp 10", bus.rs2_tag); end
        tests_run++; if (bus.rs2_val !== 32'h55) begin tests_failed++; $display("FAIL collide_val got %h exp 55", bus.rs2_val); end
    endtask

    task automatic test_clear();
        drive_rename(5'd1, 5'd5); step();
        drive_rename(5'd2, 5'd6); step();
        drive_rename(5'd3, 5'd7); step();
        idle();
        bus.rs1_addr = 5'd1;
        bus.rs2_addr = 5'd3;
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b1) begin tests_failed++; $display("FAIL pre_clear_busy1 got %b exp 1", bus.rs1_busy); end
        tests_run++; if (bus.rs2_tag !== 5'd7) begin tests_failed++; $display("FAIL pre_clear_tag3 got %0d exp 7", bus.rs2_tag); end
        clear = 1'b1;
        drive_commit(5'd1, 5'd5, 32'h40);
        drive_rename(5'd4, 5'd11);
        bus.rs2_addr = 5'd2;
        #1;
        tests_run++; if (bus.rs2_busy !== 1'b0) begin tests_failed++; $display("FAIL clear_comb_busy2 got %b exp 0", bus.rs2_busy); end
        step();
        idle();
        bus.rs1_addr = 5'd1;
        bus.rs2_addr = 5'd2;
        #1;
        tests_run++; if (bus.rs1_val !== 32'h40) begin tests_failed++; $display("FAIL clear_commit_val got %h exp 40", bus.rs1_val); end
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL clear_busy1 got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.rs2_busy !== 1'b0) begin tests_failed++; $display("FAIL clear_busy2 got %b exp 0", bus.rs2_busy); end
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd4;
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL clear_busy3 got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.rs2_busy !== 1'b0) begin tests_failed++; $display("FAIL clear_rename_ignored got %b exp 0", bus.rs2_busy); end
        bus.rs1_addr = 5'd8;
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL clear_busy8 got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.commit_count !== 32'd6) begin tests_failed++; $display("FAIL clear_count got %0d exp 6", bus.commit_count); end
    endtask

    task automatic test_rdy_low();
        rdy_in = 1'b0;
        drive_commit(5'd9, 5'd1, 32'h99);
        drive_rename(5'd10, 5'd12);
        step();
        idle();
        rdy_in = 1'b1;
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd10;
        #1;
        tests_run++; if (bus.rs1_val !== 32'd0) begin tests_failed++; $display("FAIL rdy_low_val got %h exp 0", bus.rs1_val); end
        tests_run++; if (bus.rs2_busy !== 1'b0) begin tests_failed++; $display("FAIL rdy_low_busy got %b exp 0", bus.rs2_busy); end
        tests_run++; if (bus.commit_count !== 32'd6) begin tests_failed++; $display("FAIL rdy_low_count got %0d exp 6", bus.commit_count); end
    endtask

    task automatic test_x0();
        drive_rename(5'd0, 5'd13);
        drive_commit(5'd0, 5'd13, 32'hFFFF);
        bus.rs1_addr = 5'd0;
        #1;
        tests_run++; if (bus.rs1_val !== 32'd0) begin tests_failed++; $display("FAIL x0_bypass_val got %h exp 0", bus.rs1_val); end
        step();
        idle();
        #1;
        tests_run++; if (bus.rs1_val !== 32'd0) begin tests_failed++; $display("FAIL x0_val got %h exp 0", bus.rs1_val); end
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL x0_busy got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.rs1_tag !== 5'd0) begin tests_failed++; $display("FAIL x0_tag got %0d exp 0", bus.rs1_tag); end
        tests_run++; if (bus.commit_count !== 32'd7) begin tests_failed++; $display("FAIL x0_count got %0d exp 7", bus.commit_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_commit(5'(20 + i), 5'(16 + i), 32'h101 * (i + 1));
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.rs1_addr = 5'(20 + i);
            #1;
            tests_run++; if (bus.rs1_val !== 32'h101 * (i + 1)) begin tests_failed++; $display("FAIL b2b_val x%0d got %h exp %h", 20 + i, bus.rs1_val, 32'h101 * (i + 1)); end
        end
        tests_run++; if (bus.commit_count !== 32'd11) begin tests_failed++; $display("FAIL b2b_count got %0d exp 11", bus.commit_count); end
    endtask

    task automatic test_async_reset();
        drive_rename(5'd11, 5'd14);
        drive_commit(5'd12, 5'd0, 32'h77);
        step();
        idle();
        bus.rs1_addr = 5'd11;
        bus.rs2_addr = 5'd12;
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b1) begin tests_failed++; $display("FAIL pre_rst_busy got %b exp 1", bus.rs1_busy); end
        tests_run++; if (bus.rs2_val !== 32'h77) begin tests_failed++; $display("FAIL pre_rst_val got %h exp 77", bus.rs2_val); end
        #1 rst_in = 1'b0;
        #1;
        tests_run++; if (bus.rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL async_rst_busy got %b exp 0", bus.rs1_busy); end
        tests_run++; if (bus.rs1_tag !== 5'd0) begin tests_failed++; $display("FAIL async_rst_tag got %0d exp 0", bus.rs1_tag); end
        tests_run++; if (bus.rs2_val !== 32'd0) begin tests_failed++; $display("FAIL async_rst_val got %h exp 0", bus.rs2_val); end
        tests_run++; if (bus.commit_count !== 32'd0) begin tests_failed++; $display("FAIL async_rst_count got %0d exp 0", bus.commit_count); end
        #1 rst_in = 1'b1;
        step();
    endtask

    // Test sequence and final report
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        test_reset();
        test_commit_bypass();
        test_rename_commit();
        test_younger_writer();
        test_same_cycle_rename_commit();
        test_clear();
        test_rdy_low();
        test_x0();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
